rand_roll_ctrl: RTL and testbench

- Lab 1 random-number core. Sits between the two debounced key pulses (start, memory) and the two 7-segment hex decoders.
- On a start pulse it "rolls" a 4-bit pseudo-random value, updating the display at progressively slower intervals until it settles on a final result.
- It keeps the previous final result, which a memory pulse pushes to the second display.

---
 rtl/rand_roll_ctrl.sv | 127 ++++++++++++
 tb/tb_rand_roll_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_roll_ctrl.sv
// Random-number roll controller: free-running 16-bit LFSR sampled at
// progressively slower intervals after a start pulse, with last/previous result recall.
module rand_roll_ctrl #(
    parameter int          P_BASE_PERIOD = 2_500_000,
    parameter int          P_NUM_STEPS   = 12,
    parameter logic [15:0] P_SEED        = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mem,
    output logic [3:0] o_random_out,
    output logic [3:0] o_random_mem_out,
    output logic       o_busy,
    output logic       o_done
);

    localparam int LP_CNT_W  = ($clog2(P_BASE_PERIOD * P_NUM_STEPS) > 0) ?
                               $clog2(P_BASE_PERIOD * P_NUM_STEPS) : 1;
    localparam int LP_STEP_W = $clog2(P_NUM_STEPS + 1);

    localparam logic [LP_CNT_W-1:0]  LP_FIRST_LIMIT = LP_CNT_W'(P_BASE_PERIOD - 1);
    localparam logic [LP_CNT_W-1:0]  LP_PERIOD      = LP_CNT_W'(P_BASE_PERIOD);
    localparam logic [LP_STEP_W-1:0] LP_LAST_STEP   = LP_STEP_W'(P_NUM_STEPS - 1);

    typedef enum logic {
        S_IDLE,
        S_ROLL
    } state_t;

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic [LP_STEP_W-1:0] r_step;
    logic [LP_CNT_W-1:0]  r_cnt;
    logic [LP_CNT_W-1:0]  r_limit;
    logic [3:0]           r_last_result;
    logic [3:0]           r_prev_result;
    logic [3:0]           r_random_out;
    logic [3:0]           r_random_mem_out;
    logic                 r_busy;
    logic                 r_done;

    logic [15:0]          w_lfsr_next;
    logic                 w_interval_end;
    logic                 w_last_step;

    assign w_lfsr_next    = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_interval_end = (r_cnt == r_limit);
    assign w_last_step    = (r_step == LP_LAST_STEP);

    // The LFSR never pauses, so the roll outcome depends on when the key is pressed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lfsr <= P_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // r_limit tracks P_BASE_PERIOD*(step+1)-1 incrementally, avoiding a multiplier.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_step           <= '0;
            r_cnt            <= '0;
            r_limit          <= LP_FIRST_LIMIT;
            r_last_result    <= 4'd0;
            r_prev_result    <= 4'd0;
            r_random_out     <= 4'd0;
            r_random_mem_out <= 4'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_mem) begin
                r_random_mem_out <= r_prev_result;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ROLL;
                        r_cnt   <= '0;
                        r_step  <= '0;
                        r_limit <= LP_FIRST_LIMIT;
                        r_busy  <= 1'b1;
                    end
                end

                S_ROLL: begin
                    if (w_interval_end) begin
                        r_random_out <= r_lfsr[3:0];
                        r_cnt        <= '0;
                        r_step       <= r_step + 1'b1;
                        r_limit      <= r_limit + LP_PERIOD;
                        if (w_last_step) begin
                            r_prev_result <= r_last_result;
                            r_last_result <= r_lfsr[3:0];
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // NOTE: non-blocking assignments let this later restart override the
                    // cnt/step/state updates above while the final-result writes still land.
                    if (i_start) begin
                        r_state <= S_ROLL;
                        r_cnt   <= '0;
                        r_step  <= '0;
                        r_limit <= LP_FIRST_LIMIT;
                        r_busy  <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_random_out     = r_random_out;
    assign o_random_mem_out = r_random_mem_out;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule

// File: tb/tb_rand_roll_ctrl.sv
// Self-checking bench for rand_roll_ctrl: an LFSR reference model predicts each display
// update at start time, and every output is compared on every falling edge.
module tb_rand_roll_ctrl;

    localparam int          BP   = 4;
    localparam int          NS   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int         t;
        logic [3:0] val;
        logic       fin;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_mem;
    logic [3:0] o_random_out;
    logic [3:0] o_random_mem_out;
    logic       o_busy;
    logic       o_done;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_lfsr;
    exp_t        sb[$];
    logic [3:0]  exp_out = 4'd0;
    logic [3:0]  exp_mem = 4'd0;
    logic        exp_busy = 1'b0;
    logic [3:0]  m_last = 4'd0;
    logic [3:0]  m_prev = 4'd0;

    rand_roll_ctrl #(
        .P_BASE_PERIOD(BP),
        .P_NUM_STEPS  (NS),
        .P_SEED       (SEED)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_mem           (i_mem),
        .o_random_out    (o_random_out),
        .o_random_mem_out(o_random_mem_out),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!i_rst_n) m_lfsr <= SEED;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] adv(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    // Wait for the next falling edge, retire any scheduled update, compare all outputs.
    task automatic tick();
        exp_t e;
        logic exp_done;
        @(negedge clk);
        exp_done = 1'b0;
        if (sb.size() > 0 && sb[0].t == cyc) begin
            e       = sb.pop_front();
            exp_out = e.val;
            if (e.fin) begin
                exp_done = 1'b1;
                m_prev   = m_last;
                m_last   = e.val;
                if (sb.size() == 0) exp_busy = 1'b0;
            end
        end
        vectors++;
        if (o_random_out !== exp_out) begin
            miscompares++;
            $display("FAIL random_out cyc=%0d got=%h exp=%h", cyc, o_random_out, exp_out);
        end
        vectors++;
        if (o_random_mem_out !== exp_mem) begin
            miscompares++;
            $display("FAIL random_mem_out cyc=%0d got=%h exp=%h", cyc, o_random_mem_out, exp_mem);
        end
        vectors++;
        if (o_busy !== exp_busy) begin
            miscompares++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, exp_busy);
        end
        vectors++;
        if (o_done !== exp_done) begin
            miscompares++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, o_done, exp_done);
        end
        i_start = 1'b0;
        i_mem   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive a start pulse for the next edge and push the predicted updates of that roll.
    task automatic do_start();
        int          t0;
        int          off;
        logic [15:0] v;
        exp_t        e;
        t0 = cyc + 1;
        while (sb.size() > 0 && sb[$].t > t0) void'(sb.pop_back());
        for (int n = 1; n <= NS; n++) begin
            off   = BP * n * (n + 1) / 2;
            v     = adv(m_lfsr, off);
            e.t   = t0 + off;
            e.val = v[3:0];
            e.fin = (n == NS);
            sb.push_back(e);
        end
        i_start  = 1'b1;
        exp_busy = 1'b1;
    endtask

    task automatic drive_mem();
        i_mem   = 1'b1;
        exp_mem = m_prev;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_start = 1'b1;
            tick();
        end
        vectors++;
        if (dut.r_lfsr !== SEED) begin
            miscompares++;
            $display("FAIL lfsr_in_reset got=%h exp=%h", dut.r_lfsr, SEED);
        end
        i_rst_n = 1'b1;
        tick();
        vectors++;
        if (dut.r_lfsr !== 16'h59C3) begin
            miscompares++;
            $display("FAIL lfsr_first_step got=%h exp=59c3", dut.r_lfsr);
        end
        ticks(5);
    endtask

    task automatic test_basic_roll();
        do_start();
        ticks(26);
        ticks(3);
    endtask

    task automatic test_mem_recall();
        logic [3:0] a;
        logic [3:0] b;
        a = m_last;
        do_start();
        ticks(27);
        drive_mem();
        tick();
        vectors++;
        if (o_random_mem_out !== a) begin
            miscompares++;
            $display("FAIL mem_recall_A got=%h exp=%h", o_random_mem_out, a);
        end
        b = m_last;
        ticks(7);
        do_start();
        ticks(26);
        drive_mem();
        tick();
        vectors++;
        if (o_random_mem_out !== b) begin
            miscompares++;
            $display("FAIL mem_recall_B got=%h exp=%h", o_random_mem_out, b);
        end
        ticks(2);
    endtask

    task automatic test_restart();
        do_start();
        ticks(10);
        do_start();
        ticks(26);
        ticks(2);
    endtask

    task automatic test_final_start_mem();
        logic [3:0] old_prev;
        do_start();
        ticks(24);
        old_prev = m_prev;
        do_start();
        drive_mem();
        tick();
        vectors++;
        if (o_done !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL final_start done/busy got=%b%b exp=11", o_done, o_busy);
        end
        vectors++;
        if (o_random_mem_out !== old_prev) begin
            miscompares++;
            $display("FAIL final_start_mem got=%h exp=%h", o_random_mem_out, old_prev);
        end
        ticks(26);
        ticks(2);
    endtask

    task automatic test_reset_mid_roll();
        do_start();
        ticks(13);
        i_rst_n = 1'b0;
        sb.delete();
        exp_out  = 4'd0;
        exp_mem  = 4'd0;
        exp_busy = 1'b0;
        m_last   = 4'd0;
        m_prev   = 4'd0;
        tick();
        i_rst_n = 1'b1;
        ticks(30);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_mem   = 1'b0;
        test_reset();
        test_basic_roll();
        test_mem_recall();
        test_restart();
        test_final_start_mem();
        test_reset_mid_roll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
